// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NUM_REQ requesters,
// with credit tracking of FIFO occupancy and locked multi-beat bursts.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          rd_en,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full
);
    // Handshake: a requester holds req (and req_data) high; the beat transfers on
    // the posedge that ends a cycle in which its gnt bit is high. gnt never depends
    // on a same-cycle rd_en, only on the registered level.
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state, state_next;
    logic [PW-1:0]           rr_ptr, rr_ptr_next;
    logic [PW-1:0]           lock_owner, lock_owner_next;
    logic [PW-1:0]           gnt_idx;
    logic                    gnt_any;
    logic                    rd_take;
    logic [LW-1:0]           level_q;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

    assign level   = level_q;
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign rd_take = rd_en && (level_q != '0);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        int idx;
        idx             = 0;
        gnt             = '0;
        gnt_any         = 1'b0;
        gnt_idx         = '0;
        state_next      = state;
        rr_ptr_next     = rr_ptr;
        lock_owner_next = lock_owner;
        if (state == LOCKED) begin
            if (!req[lock_owner]) begin
                state_next = ARB;
            end else if (!reset && !full) begin
                gnt_any = 1'b1;
                gnt_idx = lock_owner;
                if (!req_lock[lock_owner]) state_next = ARB;
            end
        end else if (!reset && !full) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_any && req[PW'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
            if (gnt_any) begin
                rr_ptr_next = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (req_lock[gnt_idx]) begin
                    state_next      = LOCKED;
                    lock_owner_next = gnt_idx;
                end
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= '0;
            lock_owner <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            level_q    <= '0;
        end else begin
            state      <= state_next;
            rr_ptr     <= rr_ptr_next;
            lock_owner <= lock_owner_next;
            wr_en      <= gnt_any;
            if (gnt_any) wr_data <= data_arr[gnt_idx];
            // Credit is taken at grant time so the in-flight write is already counted.
            if (gnt_any && !rd_take) begin
                level_q <= level_q + 1'b1;
            end else if (!gnt_any && rd_take) begin
                level_q <= level_q - 1'b1;
            end
        end
    end
endmodule
